// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer sharing one 32-bit adder (shift-add / restoring divide).
// Optional build macro MULDIV_EARLY_OUT_EN: trivial operands finish without entering RUN.

module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;

  logic             is_div;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic             early;
  logic [WIDTH-1:0] early_result;

  assign is_div = op_r[1];

  // hi doubles as the partial remainder and lo as the quotient while dividing
  always_comb begin
    r_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};
    if (is_div) begin
      add_a   = r_shift;
      add_b   = ~opnd;
      add_cin = 1'b1;
    end else begin
      add_a   = hi;
      add_b   = opnd;
      add_cin = 1'b0;
    end
  end

  adder_32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (sum),
    .cout (cout)
  );

  // hi[31] is the bit shifted out of the remainder; when set, r' exceeds any divisor
  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (is_div) begin
      if (hi[WIDTH-1] | cout) begin
        hi_nxt = sum;
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = r_shift;
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      hi_nxt = {cout, sum[WIDTH-1:1]};
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_nxt = {1'b0, hi[WIDTH-1:1]};
      lo_nxt = {hi[0], lo[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early        = op[1] ? (data2 == '0) : ((data1 == '0) || (data2 == '0));
    early_result = op[1] ? (op[0] ? data1 : '1) : '0;
  end
`else
  always_comb begin
    early        = 1'b0;
    early_result = '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_r     <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            op_r <= op;
            opnd <= op[1] ? data2 : data1;
            hi   <= '0;
            lo   <= op[1] ? data1 : data2;
            cnt  <= '0;
            if (early) begin
              state    <= DONE;
              done     <= 1'b1;
              result   <= early_result;
              div_zero <= op[1];
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              result   <= op_r[0] ? hi_nxt : lo_nxt;
              div_zero <= op_r[1] && (opnd == '0);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors push expected results, a monitor pops them on done.
// Latency expectations follow MULDIV_EARLY_OUT_EN when the bench is built with it.

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t scb[$];
  exp_t mon_e;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .data1    (data1),
    .data2    (data2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got result 0x%08h with no outstanding request", result);
      end else begin
        mon_e = scb.pop_front();
        checkOutput("result", result, mon_e.r);
        checkOutput("div_zero", {31'd0, div_zero}, {31'd0, mon_e.dz});
      end
    end
  end

  function automatic int expLat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic trivial;
    trivial = o[1] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));
    return (EARLY && trivial) ? 1 : 33;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_dz, input bit push);
    exp_t e;
    op    = o;
    data1 = a;
    data2 = b;
    start = 1'b1;
    if (push) begin
      e.r  = exp_r;
      e.dz = exp_dz;
      scb.push_back(e);
    end
  endtask

  // Counts cycles after the start cycle until done; optional ignored start pulses in cycles 3..20
  task automatic waitDone(input int lat, input bit noise);
    int done_cyc = 0;
    int busy_cnt = 0;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      @(posedge clk);
      #1;
      start = noise && cyc >= 3 && cyc <= 20;
      if (start) begin
        op    = 2'b11;
        data1 = 32'hDEAD0000;
        data2 = 32'h0;
      end
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cyc = cyc;
    end
    start = 1'b0;
    if (done_cyc == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done within 60 cycles, expected done in cycle %0d", lat);
    end else begin
      checkOutput("done_cycle", 32'(done_cyc), 32'(lat));
      checkOutput("busy_cycles", 32'(busy_cnt), 32'(lat - 1));
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_r, input logic exp_dz, input bit noise);
    @(posedge clk);
    #1;
    issue(o, a, b, exp_r, exp_dz, 1'b1);
    waitDone(expLat(o, a, b), noise);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    data1 = '0;
    data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_div_zero", {31'd0, div_zero}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b0, 1'b1);
    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    applyStimulus(2'b01, 32'h80000000, 32'd4, 32'h00000002, 1'b0, 1'b0);
    applyStimulus(2'b00, 32'd0, 32'd5, 32'h00000000, 1'b0, 1'b0);
    applyStimulus(2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
    applyStimulus(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
    applyStimulus(2'b10, 32'h80000000, 32'd1, 32'h80000000, 1'b0, 1'b0);
    applyStimulus(2'b10, 32'h1234, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
    applyStimulus(2'b11, 32'h1234, 32'd0, 32'h00001234, 1'b1, 1'b0);

    // Asynchronous reset in the middle of RUN discards the operation
    @(posedge clk);
    #1;
    issue(2'b00, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_reset_done", {31'd0, done}, 32'd0);
    checkOutput("async_reset_result", result, 32'd0);
    checkOutput("async_reset_div_zero", {31'd0, div_zero}, 32'd0);
    #1 rst = 1'b0;

    applyStimulus(2'b11, 32'h1234, 32'd0, 32'h00001234, 1'b1, 1'b0);
    applyStimulus(2'b10, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b0);

    // Flush in cycle 10 returns to IDLE in cycle 11 with no done and result untouched
    @(posedge clk);
    #1;
    issue(2'b10, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = (cyc == 10);
      @(negedge clk);
      if (cyc == 10) checkOutput("flush_busy_before", {31'd0, busy}, 32'd1);
      if (cyc == 11) begin
        checkOutput("flush_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("flush_done", {31'd0, done}, 32'd0);
        checkOutput("flush_result_held", result, 32'd100);
      end
    end
    flush = 1'b0;
    repeat (40) @(negedge clk);

    // Back-to-back: start accepted in the DONE cycle, next done exactly 33 cycles later
    applyStimulus(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
    issue(2'b10, 32'd1000, 32'd3, 32'h0000014D, 1'b0, 1'b1);
    waitDone(33, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(scb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running at 100000, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
